decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/decode_pkg.sv | 47 ++++
 rtl/decode_regfile.sv | 38 +++
 rtl/decode.sv | 190 +++++++++++++++++++
 tb/tb_decode.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared constants and types for the decode stage:
//   XLEN            default data/address width
//   OPC_*           RV32I + Zicsr major opcodes
//   NOP_INST        canonical bubble encoding (ADDI x0,x0,0)
//   dec_fields_t    every non-XLEN output register of the stage, bundled
//   BUBBLE_FIELDS   field values loaded when the stage inserts a bubble
// -----------------------------------------------------------------------------
package decode_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [11:0] csr_addr;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        valid;
      logic        illegal;
   } dec_fields_t;

   // A bubble carries the fields of NOP_INST (only the opcode is non-zero)
   // with every control and valid cleared.
   localparam dec_fields_t BUBBLE_FIELDS = '{opcode: NOP_INST[6:0], default: '0};

endpackage

// File: rtl/decode_regfile.sv
// -----------------------------------------------------------------------------
// decode_regfile
// 32 x XLEN integer register file. x0 always reads zero.
//   i_clk, i_rst_n      clock, asynchronous active-low reset (clears all regs)
//   i_ra1, i_ra2        asynchronous read addresses
//   o_rd1, o_rd2        read data
//   i_we, i_wa, i_wd    synchronous write port (writes to x0 are dropped)
// -----------------------------------------------------------------------------
module decode_regfile #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [4:0]      i_ra1,
   input  logic [4:0]      i_ra2,
   output logic [XLEN-1:0] o_rd1,
   output logic [XLEN-1:0] o_rd2,
   input  logic            i_we,
   input  logic [4:0]      i_wa,
   input  logic [XLEN-1:0] i_wd
);

   logic [XLEN-1:0] regs_q [32];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else if (i_we && (i_wa != 5'd0)) begin
         regs_q[i_wa] <= i_wd;
      end
   end

   assign o_rd1 = (i_ra1 == 5'd0) ? '0 : regs_q[i_ra1];
   assign o_rd2 = (i_ra2 == 5'd0) ? '0 : regs_q[i_ra2];

endmodule

// File: rtl/decode.sv
// -----------------------------------------------------------------------------
// decode
// Instruction decode stage: splits the fetched instruction into fields,
// builds the sign-extended immediate, reads operands (with writeback
// bypass), generates controls and detects load-use hazards.
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_stall, i_flush        downstream hold / branch flush
//   i_inst_data, i_pc       instruction and its PC from fetch
//   i_wb_en/_rd/_data       writeback port into the register file
//   o_*                     registered decode results (o_valid=0 is a bubble)
//   o_stall_req             combinational load-use stall request to fetch
//
// Flow control: the stage registers update on every clock. i_flush loads a
// bubble and wins over everything; i_stall alone freezes every output
// register; o_stall_req asks fetch to present the same instruction again
// while the stage inserts one bubble, so the load result can be forwarded.
// -----------------------------------------------------------------------------
module decode
   import decode_pkg::*;
#(
   parameter int XLEN = decode_pkg::XLEN
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_stall,
   input  logic            i_flush,
   input  logic [31:0]     i_inst_data,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_wb_en,
   input  logic [4:0]      i_wb_rd,
   input  logic [XLEN-1:0] i_wb_data,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_rs1_data,
   output logic [XLEN-1:0] o_rs2_data,
   output logic [XLEN-1:0] o_imm,
   output logic [4:0]      o_rs1,
   output logic [4:0]      o_rs2,
   output logic [4:0]      o_rd,
   output logic [6:0]      o_opcode,
   output logic [2:0]      o_funct3,
   output logic [6:0]      o_funct7,
   output logic [11:0]     o_csr_addr,
   output logic            o_reg_write,
   output logic            o_mem_read,
   output logic            o_mem_write,
   output logic            o_valid,
   output logic            o_illegal,
   output logic            o_stall_req
);

   logic [31:0]     inst;
   logic [6:0]      opc;
   logic [4:0]      rs1, rs2;
   logic [XLEN-1:0] rf_rd1, rf_rd2, rs1_val, rs2_val;
   logic            use_rs1, use_rs2, load_use, bubble;

   dec_fields_t     dec_d, fields_q;
   logic [31:0]     imm32;
   logic            zimm_sel;
   logic [XLEN-1:0] imm_d, imm_q, pc_q, rs1_data_q, rs2_data_q;

   assign inst = i_inst_data;
   assign opc  = inst[6:0];
   assign rs1  = inst[19:15];
   assign rs2  = inst[24:20];

   decode_regfile #(.XLEN(XLEN)) u_regfile (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_ra1   (rs1),
      .i_ra2   (rs2),
      .o_rd1   (rf_rd1),
      .o_rd2   (rf_rd2),
      .i_we    (i_wb_en),
      .i_wa    (i_wb_rd),
      .i_wd    (i_wb_data)
   );

   // Write-through: a value being written this cycle is seen by the read.
   assign rs1_val = (rs1 != 5'd0 && i_wb_en && i_wb_rd == rs1) ? i_wb_data : rf_rd1;
   assign rs2_val = (rs2 != 5'd0 && i_wb_en && i_wb_rd == rs2) ? i_wb_data : rf_rd2;

   // Source usage for hazard detection: rs1 is read by everything except
   // the U/J forms, rs2 only by the R/S/B forms.
   assign use_rs1 = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
   assign use_rs2 = (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);

   assign load_use = fields_q.valid && fields_q.mem_read && (fields_q.rd != 5'd0) &&
                     ((use_rs1 && rs1 == fields_q.rd) || (use_rs2 && rs2 == fields_q.rd));
   assign o_stall_req = load_use;

   always_comb begin
      dec_d          = '0;
      dec_d.opcode   = opc;
      dec_d.funct3   = inst[14:12];
      dec_d.funct7   = inst[31:25];
      dec_d.rd       = inst[11:7];
      dec_d.rs1      = rs1;
      dec_d.rs2      = rs2;
      dec_d.valid    = 1'b1;
      imm32          = '0;
      zimm_sel       = 1'b0;
      case (opc)
         OPC_LUI, OPC_AUIPC: begin
            imm32           = {inst[31:12], 12'b0};
            dec_d.reg_write = 1'b1;
         end
         OPC_JAL: begin
            imm32           = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            dec_d.reg_write = 1'b1;
         end
         OPC_JALR, OPC_OP_IMM: begin
            imm32           = {{20{inst[31]}}, inst[31:20]};
            dec_d.reg_write = 1'b1;
         end
         OPC_LOAD: begin
            imm32           = {{20{inst[31]}}, inst[31:20]};
            dec_d.reg_write = 1'b1;
            dec_d.mem_read  = 1'b1;
         end
         OPC_MISC_MEM: begin
            imm32 = {{20{inst[31]}}, inst[31:20]};
         end
         OPC_STORE: begin
            imm32           = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            dec_d.mem_write = 1'b1;
         end
         OPC_BRANCH: begin
            imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         end
         OPC_OP: begin
            dec_d.reg_write = 1'b1;
         end
         OPC_SYSTEM: begin
            // CSR immediate forms carry a zero-extended zimm in the rs1 slot;
            // ECALL/EBREAK (funct3=0) write nothing.
            dec_d.csr_addr  = inst[31:20];
            dec_d.reg_write = (inst[14:12] != 3'b000);
            zimm_sel        = inst[14];
         end
         default: begin
            dec_d.illegal = 1'b1;
         end
      endcase
      dec_d.reg_write = dec_d.reg_write && (dec_d.rd != 5'd0);
      imm_d = zimm_sel ? XLEN'(inst[19:15]) : XLEN'($signed(imm32));
   end

   assign bubble = i_flush || (!i_stall && load_use);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fields_q   <= '0;
         pc_q       <= '0;
         imm_q      <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
      end else if (bubble) begin
         fields_q   <= BUBBLE_FIELDS;
         pc_q       <= i_pc;
         imm_q      <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
      end else if (!i_stall) begin
         fields_q   <= dec_d;
         pc_q       <= i_pc;
         imm_q      <= imm_d;
         rs1_data_q <= rs1_val;
         rs2_data_q <= rs2_val;
      end
   end

   assign o_pc        = pc_q;
   assign o_rs1_data  = rs1_data_q;
   assign o_rs2_data  = rs2_data_q;
   assign o_imm       = imm_q;
   assign o_rs1       = fields_q.rs1;
   assign o_rs2       = fields_q.rs2;
   assign o_rd        = fields_q.rd;
   assign o_opcode    = fields_q.opcode;
   assign o_funct3    = fields_q.funct3;
   assign o_funct7    = fields_q.funct7;
   assign o_csr_addr  = fields_q.csr_addr;
   assign o_reg_write = fields_q.reg_write;
   assign o_mem_read  = fields_q.mem_read;
   assign o_mem_write = fields_q.mem_write;
   assign o_valid     = fields_q.valid;
   assign o_illegal   = fields_q.illegal;

endmodule

// File: tb/tb_decode.sv
// -----------------------------------------------------------------------------
// tb_decode
// Directed and randomized checks of the decode stage against a behavioural
// model built from the instruction-format rules.
// -----------------------------------------------------------------------------
module tb_decode;
   import decode_pkg::*;

   // ---------------- clock / reset ----------------
   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_stall, i_flush, i_wb_en;
   logic [31:0] i_inst_data, i_pc, i_wb_data;
   logic [4:0]  i_wb_rd;
   logic [31:0] o_pc, o_rs1_data, o_rs2_data, o_imm;
   logic [4:0]  o_rs1, o_rs2, o_rd;
   logic [6:0]  o_opcode, o_funct7;
   logic [2:0]  o_funct3;
   logic [11:0] o_csr_addr;
   logic        o_reg_write, o_mem_read, o_mem_write, o_valid, o_illegal, o_stall_req;

   always #5 i_clk = ~i_clk;

   decode #(.XLEN(32)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_flush(i_flush),
      .i_inst_data(i_inst_data), .i_pc(i_pc), .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd),
      .i_wb_data(i_wb_data), .o_pc(o_pc), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
      .o_imm(o_imm), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_opcode(o_opcode),
      .o_funct3(o_funct3), .o_funct7(o_funct7), .o_csr_addr(o_csr_addr),
      .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
      .o_valid(o_valid), .o_illegal(o_illegal), .o_stall_req(o_stall_req)
   );

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] pc, rs1d, rs2d, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [6:0]  opc, f7;
      logic [2:0]  f3;
      logic [11:0] csr;
      logic        rw, mr, mw, v, ill;
   } exp_t;

   exp_t        exp_s;
   exp_t        exp_q[$];
   logic [31:0] ref_regs [32];
   int          checks = 0;
   int          errors = 0;

   function automatic logic [31:0] imm_i(logic [31:0] inst);
      int v;
      v = $signed(inst) >>> 20;
      return v;
   endfunction

   function automatic logic [31:0] imm_s(logic [31:0] inst);
      int v;
      v = ($signed(inst) >>> 25) * 32 + int'(inst[11:7]);
      return v;
   endfunction

   function automatic logic [31:0] imm_b(logic [31:0] inst);
      int v;
      v = ($signed(inst) >>> 31) * 4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 +
          int'(inst[11:8]) * 2;
      return v;
   endfunction

   function automatic logic [31:0] imm_j(logic [31:0] inst);
      int v;
      v = ($signed(inst) >>> 31) * (1 << 20) + int'(inst[19:12]) * 4096 +
          int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
      return v;
   endfunction

   function automatic logic [31:0] rd_op(logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (i_wb_en && i_wb_rd == r) return i_wb_data;
      return ref_regs[r];
   endfunction

   function automatic logic exp_req(logic [31:0] inst);
      logic [6:0] op = inst[6:0];
      logic u1 = !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
      logic u2 = (op == OPC_OP || op == OPC_STORE || op == OPC_BRANCH);
      return exp_s.v && exp_s.mr && exp_s.rd != 5'd0 &&
             ((u1 && inst[19:15] == exp_s.rd) || (u2 && inst[24:20] == exp_s.rd));
   endfunction

   function automatic exp_t ref_decode(logic [31:0] inst);
      exp_t n = '0;
      logic [6:0] op = inst[6:0];
      n.v = 1'b1;  n.pc = i_pc;  n.opc = op;  n.f3 = inst[14:12];  n.f7 = inst[31:25];
      n.rd = inst[11:7];  n.rs1 = inst[19:15];  n.rs2 = inst[24:20];
      n.rs1d = rd_op(inst[19:15]);
      n.rs2d = rd_op(inst[24:20]);
      case (op)
         OPC_LUI, OPC_AUIPC: begin n.imm = inst & 32'hFFFF_F000; n.rw = 1'b1; end
         OPC_JAL:            begin n.imm = imm_j(inst); n.rw = 1'b1; end
         OPC_JALR, OPC_OP_IMM: begin n.imm = imm_i(inst); n.rw = 1'b1; end
         OPC_LOAD:           begin n.imm = imm_i(inst); n.rw = 1'b1; n.mr = 1'b1; end
         OPC_MISC_MEM:       n.imm = imm_i(inst);
         OPC_STORE:          begin n.imm = imm_s(inst); n.mw = 1'b1; end
         OPC_BRANCH:         n.imm = imm_b(inst);
         OPC_OP:             n.rw = 1'b1;
         OPC_SYSTEM: begin
            n.csr = inst[31:20];
            n.rw  = (inst[14:12] != 3'd0);
            n.imm = inst[14] ? 32'(inst[19:15]) : 32'd0;
         end
         default:            n.ill = 1'b1;
      endcase
      n.rw = n.rw && (n.rd != 5'd0);
      return n;
   endfunction

   // One clock of the model, evaluated on the inputs currently driven.
   task automatic model_step();
      exp_t n = exp_s;
      if (i_flush || (!i_stall && exp_req(i_inst_data))) begin
         n = '0;  n.opc = 7'h13;  n.pc = i_pc;
      end else if (!i_stall) begin
         n = ref_decode(i_inst_data);
      end
      if (i_wb_en && i_wb_rd != 5'd0) ref_regs[i_wb_rd] = i_wb_data;
      exp_s = n;
      exp_q.push_back(n);
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic check_outputs(input string tag);
      exp_t e = exp_q.pop_front();
      chk({tag, ".pc"}, o_pc, e.pc);
      chk({tag, ".rs1_data"}, o_rs1_data, e.rs1d);
      chk({tag, ".rs2_data"}, o_rs2_data, e.rs2d);
      chk({tag, ".imm"}, o_imm, e.imm);
      chk({tag, ".rs1"}, 32'(o_rs1), 32'(e.rs1));
      chk({tag, ".rs2"}, 32'(o_rs2), 32'(e.rs2));
      chk({tag, ".rd"}, 32'(o_rd), 32'(e.rd));
      chk({tag, ".opcode"}, 32'(o_opcode), 32'(e.opc));
      chk({tag, ".funct3"}, 32'(o_funct3), 32'(e.f3));
      chk({tag, ".funct7"}, 32'(o_funct7), 32'(e.f7));
      chk({tag, ".csr_addr"}, 32'(o_csr_addr), 32'(e.csr));
      chk({tag, ".ctrl"}, {27'd0, o_reg_write, o_mem_read, o_mem_write, o_valid, o_illegal},
          {27'd0, e.rw, e.mr, e.mw, e.v, e.ill});
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic stall,
                        input logic flush, input logic wbe, input logic [4:0] wrd,
                        input logic [31:0] wdat);
      i_inst_data = inst;  i_pc = pc;  i_stall = stall;  i_flush = flush;
      i_wb_en = wbe;  i_wb_rd = wrd;  i_wb_data = wdat;
   endtask

   // Called just after a rising edge with the inputs already driven.
   task automatic cycle(input string tag);
      #1;
      chk({tag, ".stall_req"}, 32'(o_stall_req), 32'(exp_req(i_inst_data)));
      model_step();
      @(posedge i_clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic async_reset(input string tag);
      i_rst_n = 1'b0;
      #1;
      for (int r = 0; r < 32; r++) ref_regs[r] = 32'd0;
      exp_s = '0;
      exp_q.push_back(exp_s);
      check_outputs(tag);
      chk({tag, ".stall_req"}, 32'(o_stall_req), 32'd0);
      #1 i_rst_n = 1'b1;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] inst = $urandom;
      case ($urandom_range(0, 11))
         0: inst[6:0] = OPC_LUI;      1: inst[6:0] = OPC_AUIPC;
         2: inst[6:0] = OPC_JAL;      3: inst[6:0] = OPC_JALR;
         4: inst[6:0] = OPC_BRANCH;   5: inst[6:0] = OPC_LOAD;
         6: inst[6:0] = OPC_STORE;    7: inst[6:0] = OPC_OP_IMM;
         8: inst[6:0] = OPC_OP;       9: inst[6:0] = OPC_MISC_MEM;
         10: inst[6:0] = OPC_SYSTEM;  default: inst[6:0] = 7'($urandom);
      endcase
      if ($urandom_range(0, 1) == 0) begin
         inst[11:7]  = 5'($urandom_range(0, 3));
         inst[19:15] = 5'($urandom_range(0, 3));
         inst[24:20] = 5'($urandom_range(0, 3));
      end
      return inst;
   endfunction

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [31:0] cur_inst, cur_pc;
      logic        hold, st, fl, wbe;
      logic [4:0]  wrd;

      drive(NOP_INST, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      i_rst_n = 1'b1;
      #1 i_rst_n = 1'b0;
      for (int r = 0; r < 32; r++) ref_regs[r] = 32'd0;
      exp_s = '0;
      repeat (2) @(posedge i_clk);
      #1;
      exp_q.push_back(exp_s);
      check_outputs("reset");
      chk("reset.stall_req", 32'(o_stall_req), 32'd0);
      i_rst_n = 1'b1;

      // ADDI x1,x0,-5
      drive(32'hFFB0_0093, 32'h10, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      cycle("addi");
      chk("addi.imm_const", o_imm, 32'hFFFF_FFFB);
      chk("addi.rd_const", 32'(o_rd), 32'd1);
      chk("addi.rw_const", 32'(o_reg_write), 32'd1);
      chk("addi.valid_const", 32'(o_valid), 32'd1);
      chk("addi.pc_const", o_pc, 32'h10);

      // Fill the register file through the writeback port.
      for (int r = 1; r < 32; r++) begin
         drive(NOP_INST, 32'h100 + 32'(r * 4), 1'b0, 1'b0, 1'b1, 5'(r), $urandom);
         cycle("wbfill");
      end

      // LW x5,0(x2) then ADD x6,x5,x1
      drive(32'h0001_2283, 32'h200, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      cycle("lw");
      drive(32'h0012_8333, 32'h204, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      #1 chk("lu.stall_req_const", 32'(o_stall_req), 32'd1);
      cycle("lu_bubble");
      chk("lu.bubble_valid", 32'(o_valid), 32'd0);
      chk("lu.stall_req_cleared", 32'(o_stall_req), 32'd0);
      cycle("lu_add");
      chk("lu.add_valid", 32'(o_valid), 32'd1);
      chk("lu.add_rd", 32'(o_rd), 32'd6);

      // ADD x4,x3,x0 with writeback of x3 in the same cycle
      drive(32'h0001_8233, 32'h208, 1'b0, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF);
      cycle("bypass");
      chk("bypass.rs1_const", o_rs1_data, 32'hDEAD_BEEF);
      chk("bypass.rs2_const", o_rs2_data, 32'd0);

      // Flush wins over stall
      drive(32'hFFB0_0093, 32'h20C, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
      cycle("flush_stall");
      chk("flush.valid_const", 32'(o_valid), 32'd0);

      // Stall alone holds for three cycles
      drive(32'hFFB0_0093, 32'h40, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      cycle("pre_stall");
      for (int k = 0; k < 3; k++) begin
         drive(rand_inst(), 32'h44 + 32'(k * 4), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
         cycle("stall_hold");
         chk("stall.imm_const", o_imm, 32'hFFFF_FFFB);
         chk("stall.pc_const", o_pc, 32'h40);
      end

      // Unknown opcode, then write to x0 is ignored
      drive(32'h0000_007F, 32'h300, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      cycle("illegal");
      chk("illegal.flag_const", 32'(o_illegal), 32'd1);
      chk("illegal.rw_const", 32'(o_reg_write), 32'd0);
      chk("illegal.valid_const", 32'(o_valid), 32'd1);
      drive(NOP_INST, 32'h304, 1'b0, 1'b0, 1'b1, 5'd0, 32'd5);
      cycle("wb_x0");
      drive(32'h0000_03B3, 32'h308, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      cycle("read_x0");
      chk("x0.rs1_const", o_rs1_data, 32'd0);
      chk("x0.rs2_const", o_rs2_data, 32'd0);

      // JAL x1,-4 then reset mid-sequence
      drive(32'hFFDF_F0EF, 32'h400, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      cycle("jal");
      chk("jal.imm_const", o_imm, 32'hFFFF_FFFC);
      async_reset("reset_mid");
      chk("reset_mid.imm_const", o_imm, 32'd0);

      // Reset during a load-use hazard
      drive(32'h0001_2283, 32'h500, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      cycle("lw2");
      drive(32'h0012_8333, 32'h504, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      #1 chk("lu2.stall_req_const", 32'(o_stall_req), 32'd1);
      async_reset("reset_lu");
      cycle("post_reset_add");
      chk("post_reset_add.valid_const", 32'(o_valid), 32'd1);

      // Reset during a stall
      drive(32'hFFB0_0093, 32'h600, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      cycle("stall_pre_reset");
      async_reset("reset_stall");
      drive(32'hFFB0_0093, 32'h604, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      cycle("post_reset_addi");
      chk("post_reset_addi.valid_const", 32'(o_valid), 32'd1);

      // Randomized traffic; fetch re-presents the instruction while held
      hold = 1'b0;
      cur_inst = NOP_INST;
      cur_pc = 32'h1000;
      for (int k = 0; k < 400; k++) begin
         if (!hold) begin
            cur_inst = rand_inst();
            cur_pc = cur_pc + 32'd4;
         end
         st  = ($urandom_range(0, 7) == 0);
         fl  = ($urandom_range(0, 15) == 0);
         wbe = 1'($urandom_range(0, 1));
         wrd = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         drive(cur_inst, cur_pc, st, fl, wbe, wrd, $urandom);
         hold = !fl && (st || exp_req(cur_inst));
         cycle("rand");
         if ($urandom_range(0, 99) == 0) begin
            async_reset("rand_reset");
            hold = 1'b0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
